// File: rtl/router_pkg.sv
// router_pkg: shared types and constants for the router egress stage.
//   PKT_W        : routed packet width
//   *_LSB/*_MSB  : field positions inside a routed packet
//   pkt_t        : routed packet layout {par, payload, ptype, dest}
//   q_entry_t    : what a per-destination queue stores {ptype, payload}
//   parity_err() : 1 when the packet fails the even-parity check
package router_pkg;

  localparam int PKT_W    = 13;
  localparam int NUM_DEST = 4;
  localparam int ENTRY_W  = 10;

  localparam int DEST_LSB = 0;
  localparam int DEST_MSB = 1;
  localparam int TYPE_LSB = 2;
  localparam int TYPE_MSB = 3;
  localparam int PAY_LSB  = 4;
  localparam int PAY_MSB  = 11;
  localparam int PAR_BIT  = 12;

  typedef struct packed {
    logic       par;
    logic [7:0] payload;
    logic [1:0] ptype;
    logic [1:0] dest;
  } pkt_t;

  typedef struct packed {
    logic [1:0] ptype;
    logic [7:0] payload;
  } q_entry_t;

  // Even parity over all 13 bits: a good packet XORs to zero.
  function automatic logic parity_err(input pkt_t pkt);
    return ^pkt;
  endfunction

endpackage

// File: rtl/router_out_queue_sync_fifo.sv
// sync_fifo: first-word-fall-through circular buffer.
//   clk     : clock
//   rst     : asynchronous active-low reset (pointers only)
//   wr_en   : push wr_data (ignored when full)
//   wr_data : entry to push
//   rd_en   : pop the head entry (ignored when empty)
//   rd_data : head entry, valid whenever empty is low
//   empty   : no entries held
//   full    : DEPTH entries held
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_wr, do_rd;

  // The extra MSB on each pointer is a wrap bit: equal pointers mean empty,
  // equal low bits with differing wrap bits mean full.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                 (wr_ptr_q[AW] != rd_ptr_q[AW]);

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  // Head falls through combinationally from the entry at the read pointer.
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/router_out_queue.sv
// router_out_queue: egress buffering stage after router_top.
//   clk         : clock
//   rst         : asynchronous active-low reset
//   in_packet   : routed packet {par, payload[7:0], type[1:0], dest[1:0]}
//   in_valid    : upstream offers in_packet
//   in_ready    : packet accepted this cycle (parity drops always accepted)
//   out_valid   : per-destination head present
//   out_ready   : per-destination consumer takes the head
//   out_payload : per-destination head payload
//   out_type    : per-destination head type
//   full        : per-destination queue holds DEPTH entries
//   drop_cnt    : saturating count of parity-error drops
module router_out_queue
  import router_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PKT_W-1:0]              in_packet,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [NUM_DEST-1:0]           out_valid,
  input  logic [NUM_DEST-1:0]           out_ready,
  output logic [NUM_DEST-1:0][7:0]      out_payload,
  output logic [NUM_DEST-1:0][1:0]      out_type,
  output logic [NUM_DEST-1:0]           full,
  output logic [CNT_W-1:0]              drop_cnt
);

  pkt_t                 pkt;
  logic                 perr;
  logic [1:0]           dest;
  logic                 accept;
  logic [NUM_DEST-1:0]  push;
  logic [NUM_DEST-1:0]  empty;
  q_entry_t             wr_entry;
  q_entry_t             head [NUM_DEST];
  logic [CNT_W-1:0]     drop_cnt_q, drop_cnt_d;

  assign pkt  = pkt_t'(in_packet);
  assign perr = parity_err(pkt);
  assign dest = pkt.dest;

  // Bad-parity packets are swallowed regardless of queue state; good ones
  // stall only when their own destination is full.
  assign in_ready = rst && (perr || !full[dest]);
  assign accept   = in_valid && in_ready;

  assign wr_entry = '{ptype: pkt.ptype, payload: pkt.payload};

  always_comb begin
    push = '0;
    if (accept && !perr) push[dest] = 1'b1;
  end

  generate
    for (genvar gi = 0; gi < NUM_DEST; gi++) begin : g_queue
      sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
      ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push[gi]),
        .wr_data (wr_entry),
        .rd_en   (out_ready[gi]),
        .rd_data (head[gi]),
        .empty   (empty[gi]),
        .full    (full[gi])
      );

      assign out_valid[gi]   = !empty[gi];
      assign out_payload[gi] = head[gi].payload;
      assign out_type[gi]    = head[gi].ptype;
    end
  endgenerate

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (accept && perr && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) drop_cnt_q <= '0;
    else      drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;

endmodule

// File: doc/router_out_queue.md
# router_out_queue

Egress buffering stage placed directly downstream of `router_top`. It accepts 13-bit routed packets over a valid/ready handshake and checks their parity. Each good packet's payload and type are stored in one of four per-destination FIFOs, and each destination drains independently over its own valid/ready handshake. Packets with bad parity are dropped and counted.

## Interface

Parameters:
- `DEPTH`, default 4: entries per destination queue; power of two, ≥ 2.
- `CNT_W`, default 8: width of the drop counter.

Ports:
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `in_packet` in 13: packet fields:
  - [1:0] dest
  - [3:2] type
  - [11:4] payload
  - [12] even-parity bit, so that `^in_packet[12:0] == 0`
- `in_valid` in 1: upstream offers `in_packet`.
- `in_ready` out 1: stage accepts `in_packet` this cycle.
- `out_valid` out 4: queue *d* has a head entry.
- `out_ready` in 4: consumer *d* takes the head entry.
- `out_payload` out 4×8: head payload of queue *d*.
- `out_type` out 4×2: head type of queue *d*.
- `full` out 4: queue *d* holds `DEPTH` entries.
- `drop_cnt` out `CNT_W`: saturating count of parity-error drops.

## Operation

- `perr = ^in_packet[12:0]`; `dest = in_packet[1:0]`.
- `in_ready` is combinational:
  - `in_ready = rst && (perr || !full[dest])`.
  - Drops are always accepted.
  - `in_ready` does not depend on `out_ready`.
- Accept is `in_valid && in_ready` at a rising edge.
  - Accept with `perr = 0`: write {type, payload} into queue `dest`.
  - Accept with `perr = 1`: no write; `drop_cnt` increments, saturating at all-ones.
- Each queue is a circular buffer.
  - Read and write pointers are `$clog2(DEPTH)+1` bits; the MSB is the wrap bit.
  - Empty when pointers are equal.
  - Full when the low bits are equal and the MSBs differ.
- Head is first-word-fall-through:
  - `out_valid[d] = !empty[d]`.
  - `out_payload`/`out_type` are driven from the storage entry at the read pointer.
  - Contents are undefined (don't-care) when `out_valid[d] = 0`.
- Pop occurs when `out_valid[d] && out_ready[d]`; the read pointer advances.
- Simultaneous push and pop on the same non-empty queue: both occur and the occupancy is unchanged.
- Push to a full queue cannot occur, because `in_ready` is low.
  - A pop in the same cycle frees the slot only from the next cycle onward.
- Pop on an empty queue is ignored.
- Queues are fully independent. Back-pressure on one destination never stalls the others, unless the head-of-line input targets it.
- Pointer wrap is natural modulo 2·`DEPTH`; no special case is needed.

## Timing

- Reset, asynchronous on `rst` falling; values hold while `rst` is low:
  - All pointers = 0.
  - `out_valid` = 0, `full` = 0, `drop_cnt` = 0.
  - `in_ready` = 0.
- Storage RAM is not reset.
- Latency: a packet accepted at edge N produces `out_valid[dest] = 1` with its data after edge N. No same-cycle bypass from input to output.
- Pop at edge N: the next entry (if any) is presented after edge N.
- Reset mid-operation discards all queued entries immediately, and `drop_cnt` clears.
- First accept is possible at the first rising edge after `rst` deasserts.

## Structure

- Package `router_pkg` holds:
  - `PKT_W = 13`.
  - Field LSB/MSB localparams.
  - `typedef struct packed {logic par; logic [7:0] payload; logic [1:0] ptype; logic [1:0] dest;} pkt_t`.
  - `typedef struct packed {logic [1:0] ptype; logic [7:0] payload;} q_entry_t`.
  - `function parity_err(pkt_t)`.
- Sub-module `sync_fifo` (params `WIDTH`, `DEPTH`):
  - FWFT, full/empty flags, async active-low reset on pointers.
  - `router_out_queue` instantiates it four times with `WIDTH = 10`, plus the input decode and the drop counter.

## Test plan

- After reset release, send `13'h1AA4` (dest 0, type 1, payload AA, parity ok) with `out_ready = 0`.
  - Expect accept in 1 cycle.
  - Next cycle: `out_valid = 4'b0001`, `out_payload[0] = 8'hAA`, `out_type[0] = 2'b01`.
- Send `13'h0AA4`, which has a parity error.
  - Expect `in_ready = 1` and accept.
  - `drop_cnt` goes 0→1.
  - `out_valid` unchanged.
- Hold `out_ready[1] = 0` and push `DEPTH` = 4 packets to dest 1 (first `13'h0BB9`).
  - `full[1] = 1` and `in_ready` drops to 0 for a dest-1 packet.
  - A dest-2 packet is still accepted.
- On full queue 1, assert `out_ready[1]` for one cycle while offering a dest-1 packet.
  - Pop occurs and the packet is not accepted that cycle.
  - It is accepted the following cycle.
  - The drain order is exactly the push order, with wrap.
- Apply 300 consecutive parity-error packets: `drop_cnt` saturates at 255.
- With 3 entries queued in queue 0, pulse `rst` low mid-cycle.
  - Immediately: `out_valid = 0`, `drop_cnt = 0`, `in_ready = 0`.
  - After release: the queue behaves as empty.
